bus_access_sequencer: RTL and testbench

Sequences and arbitrates all memory accesses of the core onto the single 16-bit external bus. It takes requests from the execution unit (EU) and the prefetch unit (PF), forms the 20-bit physical address through one shared `physical_address_calculator`, and splits odd-address word accesses into two byte cycles. It returns data with a one-cycle acknowledge pulse.

---
 rtl/v30mz_pkg.sv | 44 ++++
 rtl/physical_address_calculator.sv | 29 ++
 rtl/bus_access_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_bus_access_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/v30mz_pkg.sv
//------------------------------------------------------------------------------
// Module   : v30mz_pkg
// Purpose  : Shared types and constants for the bus access sequencer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package v30mz_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER1 = 2'd1,
    S_XFER2 = 2'd2,
    S_RESP  = 2'd3
  } bas_state_t;

  typedef enum logic {
    OWN_EU = 1'b0,
    OWN_PF = 1'b1
  } bas_owner_t;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  // Prefetch forms CS:IP using only the displacement term.
  localparam logic [2:0] PF_FACTORS = 3'b001;

  function automatic logic [1:0] first_be(input logic odd, input logic word);
    if (odd) return BE_HI;
    else if (word) return BE_WORD;
    else return BE_LO;
  endfunction

  function automatic logic [15:0] first_lanes(input logic odd, input logic word,
                                              input logic [15:0] data);
    if (odd) return {data[7:0], 8'h00};
    else if (word) return data;
    else return {8'h00, data[7:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/physical_address_calculator.sv
//------------------------------------------------------------------------------
// Module   : physical_address_calculator
// Purpose  : {segment,4'h0} plus the enabled base/index/disp terms, mod 2^20.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module physical_address_calculator (
  input  logic [15:0] segment_i,
  input  logic [15:0] base_i,
  input  logic [15:0] index_i,
  input  logic [15:0] disp_i,
  input  logic [2:0]  factors_i,
  output logic [19:0] addr_o
);

  logic [19:0] base_term;
  logic [19:0] index_term;
  logic [19:0] disp_term;

  assign base_term  = factors_i[2] ? {4'h0, base_i}  : 20'h0_0000;
  assign index_term = factors_i[1] ? {4'h0, index_i} : 20'h0_0000;
  assign disp_term  = factors_i[0] ? {4'h0, disp_i}  : 20'h0_0000;

  assign addr_o = {segment_i, 4'h0} + base_term + index_term + disp_term;

endmodule

`default_nettype wire

// File: rtl/bus_access_sequencer.sv
//------------------------------------------------------------------------------
// Module   : bus_access_sequencer
// Purpose  : Arbitrates EU/PF accesses onto the 16-bit bus, splitting odd words.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bus_access_sequencer
  import v30mz_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        eu_req,
  input  logic        eu_we,
  input  logic        eu_word,
  input  logic [2:0]  eu_factors,
  input  logic [15:0] eu_segment,
  input  logic [15:0] eu_base,
  input  logic [15:0] eu_index,
  input  logic [15:0] eu_disp,
  input  logic [15:0] eu_wdata,
  output logic        eu_ack,
  output logic [15:0] eu_rdata,
  input  logic        pf_req,
  input  logic [15:0] pf_segment,
  input  logic [15:0] pf_offset,
  input  logic        pf_flush,
  output logic        pf_ack,
  output logic [15:0] pf_rdata,
  output logic        bus_req,
  output logic [19:0] bus_addr,
  output logic        bus_we,
  output logic [1:0]  bus_be,
  output logic [15:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [15:0] bus_rdata,
  output logic        busy
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  bas_state_t  state_q;
  bas_owner_t  owner_q;
  logic [19:0] addr_q;
  logic        word_q;
  logic        we_q;
  logic [15:0] wdata_q;
  logic [7:0]  lo_q;
  logic        flush_q;
  logic [3:0]  starve_q;
  logic        bus_req_q;
  logic [19:0] bus_addr_q;
  logic        bus_we_q;
  logic [1:0]  bus_be_q;
  logic [15:0] bus_wdata_q;
  logic        eu_ack_q;
  logic [15:0] eu_rdata_q;
  logic        pf_ack_q;
  logic [15:0] pf_rdata_q;

  logic        eu_v;
  logic        pf_v;
  logic        grant_pf;
  logic        grant_word;
  logic        grant_we;
  logic [15:0] grant_wdata;
  logic [15:0] calc_seg;
  logic [15:0] calc_base;
  logic [15:0] calc_index;
  logic [15:0] calc_disp;
  logic [2:0]  calc_factors;
  logic [19:0] calc_addr;
  logic        last_beat;
  logic        flushed;
  logic [15:0] done_rdata;

  assign eu_v     = eu_req;
  assign pf_v     = pf_req & ~pf_flush;
  assign grant_pf = pf_v & (~eu_v | (starve_q == STARVE_MAX));

  assign grant_word  = grant_pf ? 1'b1  : eu_word;
  assign grant_we    = grant_pf ? 1'b0  : eu_we;
  assign grant_wdata = grant_pf ? 16'h0 : eu_wdata;

  assign calc_seg     = grant_pf ? pf_segment : eu_segment;
  assign calc_base    = grant_pf ? 16'h0      : eu_base;
  assign calc_index   = grant_pf ? 16'h0      : eu_index;
  assign calc_disp    = grant_pf ? pf_offset  : eu_disp;
  assign calc_factors = grant_pf ? PF_FACTORS : eu_factors;

  physical_address_calculator u_pac (
    .segment_i (calc_seg),
    .base_i    (calc_base),
    .index_i   (calc_index),
    .disp_i    (calc_disp),
    .factors_i (calc_factors),
    .addr_o    (calc_addr)
  );

  // The only XFER1 completion that does not finish the access is an odd word.
  assign last_beat = bus_ready &
                     (((state_q == S_XFER1) & ~(addr_q[0] & word_q)) |
                      (state_q == S_XFER2));
  assign flushed   = flush_q | pf_flush;

  always_comb begin
    done_rdata = {8'h00, bus_rdata[7:0]};
    if (state_q == S_XFER2)  done_rdata = {bus_rdata[7:0], lo_q};
    else if (addr_q[0])      done_rdata = {8'h00, bus_rdata[15:8]};
    else if (word_q)         done_rdata = bus_rdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_EU;
      addr_q      <= '0;
      word_q      <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      lo_q        <= '0;
      flush_q     <= 1'b0;
      starve_q    <= '0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      eu_ack_q    <= 1'b0;
      eu_rdata_q  <= '0;
      pf_ack_q    <= 1'b0;
      pf_rdata_q  <= '0;
    end else begin
      eu_ack_q <= 1'b0;
      pf_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          flush_q <= 1'b0;
          if (eu_v || pf_v) begin
            owner_q     <= grant_pf ? OWN_PF : OWN_EU;
            addr_q      <= calc_addr;
            word_q      <= grant_word;
            we_q        <= grant_we;
            wdata_q     <= grant_wdata;
            bus_req_q   <= 1'b1;
            bus_addr_q  <= calc_addr;
            bus_we_q    <= grant_we;
            bus_be_q    <= first_be(calc_addr[0], grant_word);
            bus_wdata_q <= grant_we ? first_lanes(calc_addr[0], grant_word, grant_wdata) : 16'h0;
            if (grant_pf)
              starve_q <= '0;
            else if (pf_req && (starve_q != STARVE_MAX))
              starve_q <= starve_q + 4'd1;
            state_q     <= S_XFER1;
          end
        end
        S_XFER1, S_XFER2: begin
          if ((owner_q == OWN_PF) && pf_flush) flush_q <= 1'b1;
          if (last_beat) begin
            bus_req_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            if (owner_q == OWN_PF) begin
              pf_ack_q   <= ~flushed;
              pf_rdata_q <= done_rdata;
            end else begin
              eu_ack_q   <= 1'b1;
              eu_rdata_q <= done_rdata;
            end
            state_q <= S_RESP;
          end else if (bus_ready) begin
            lo_q        <= bus_rdata[15:8];
            bus_addr_q  <= addr_q + 20'd1;
            bus_be_q    <= BE_LO;
            bus_wdata_q <= we_q ? {8'h00, wdata_q[15:8]} : 16'h0;
            state_q     <= S_XFER2;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign eu_ack    = eu_ack_q;
  assign eu_rdata  = eu_rdata_q;
  // A flush arriving during RESP still cancels the prefetch acknowledge.
  assign pf_ack    = pf_ack_q & ~pf_flush;
  assign pf_rdata  = pf_rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_addr  = bus_addr_q;
  assign bus_we    = bus_we_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_bus_access_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_bus_access_sequencer
// Purpose  : Scoreboard bench for bus_access_sequencer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bus_access_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        eu_req, eu_we, eu_word;
  logic [2:0]  eu_factors;
  logic [15:0] eu_segment, eu_base, eu_index, eu_disp, eu_wdata;
  logic        eu_ack;
  logic [15:0] eu_rdata;
  logic        pf_req, pf_flush, pf_ack;
  logic [15:0] pf_segment, pf_offset, pf_rdata;
  logic        bus_req, bus_we, bus_ready, busy;
  logic [19:0] bus_addr;
  logic [1:0]  bus_be;
  logic [15:0] bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  bus_access_sequencer #(.STARVE_LIMIT(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .eu_req     (eu_req),
    .eu_we      (eu_we),
    .eu_word    (eu_word),
    .eu_factors (eu_factors),
    .eu_segment (eu_segment),
    .eu_base    (eu_base),
    .eu_index   (eu_index),
    .eu_disp    (eu_disp),
    .eu_wdata   (eu_wdata),
    .eu_ack     (eu_ack),
    .eu_rdata   (eu_rdata),
    .pf_req     (pf_req),
    .pf_segment (pf_segment),
    .pf_offset  (pf_offset),
    .pf_flush   (pf_flush),
    .pf_ack     (pf_ack),
    .pf_rdata   (pf_rdata),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_we     (bus_we),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata),
    .busy       (busy)
  );

  typedef struct {
    logic [19:0] addr;
    logic [1:0]  be;
    logic        we;
    logic [15:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic        pf;
    logic        chkd;
    logic [15:0] data;
  } ack_exp_t;

  bus_exp_t   bus_q[$];
  ack_exp_t   ack_q[$];
  logic [7:0] mem_ovr [logic [19:0]];
  int         checks   = 0;
  int         failures = 0;
  bus_exp_t   mon_e;
  ack_exp_t   mon_a;
  logic [15:0] mon_mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte memory seen by the bus: a fixed pattern unless overridden.
  function automatic logic [7:0] bb(input logic [19:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return a[7:0] ^ a[15:8] ^ {a[19:16], 4'h5};
  endfunction

  function automatic logic [19:0] phys(input logic [15:0] seg, input logic [15:0] base,
                                       input logic [15:0] idx, input logic [15:0] disp,
                                       input logic [2:0] f);
    logic [19:0] a;
    a = {seg, 4'h0};
    if (f[2]) a = a + {4'h0, base};
    if (f[1]) a = a + {4'h0, idx};
    if (f[0]) a = a + {4'h0, disp};
    return a;
  endfunction

  function automatic logic [15:0] rd_exp(input logic [19:0] x, input logic word);
    logic [19:0] x1;
    x1 = x + 20'd1;
    return word ? {bb(x1), bb(x)} : {8'h00, bb(x)};
  endfunction

  task automatic push_bus(input logic [19:0] x, input logic we, input logic word,
                          input logic [15:0] wd);
    bus_exp_t e;
    e.addr = x;
    e.we   = we;
    if (!x[0]) begin
      e.be    = word ? 2'b11 : 2'b01;
      e.wdata = word ? wd : {8'h00, wd[7:0]};
      bus_q.push_back(e);
    end else begin
      e.be    = 2'b10;
      e.wdata = {wd[7:0], 8'h00};
      bus_q.push_back(e);
      if (word) begin
        e.addr  = x + 20'd1;
        e.be    = 2'b01;
        e.wdata = {8'h00, wd[15:8]};
        bus_q.push_back(e);
      end
    end
  endtask

  task automatic push_ack(input logic pf, input logic chkd, input logic [15:0] data);
    ack_exp_t a;
    a.pf   = pf;
    a.chkd = chkd;
    a.data = data;
    ack_q.push_back(a);
  endtask

  // Bus responder and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus_req && bus_ready) begin
        if (bus_q.size() == 0) chk("bus_extra", 32'd1, 32'd0);
        else begin
          mon_e    = bus_q.pop_front();
          mon_mask = {{8{mon_e.be[1]}}, {8{mon_e.be[0]}}};
          chk("bus_addr", 32'(bus_addr), 32'(mon_e.addr));
          chk("bus_be",   32'(bus_be),   32'(mon_e.be));
          chk("bus_we",   32'(bus_we),   32'(mon_e.we));
          if (mon_e.we) chk("bus_wdata", 32'(bus_wdata & mon_mask), 32'(mon_e.wdata & mon_mask));
        end
      end
      if (eu_ack || pf_ack) begin
        if (ack_q.size() == 0) chk("ack_extra", 32'd1, 32'd0);
        else begin
          mon_a = ack_q.pop_front();
          chk("ack_owner", 32'(pf_ack), 32'(mon_a.pf));
          if (mon_a.chkd) chk("ack_rdata", 32'(pf_ack ? pf_rdata : eu_rdata), 32'(mon_a.data));
        end
      end
    end
    bus_rdata = bus_addr[0] ? {bb(bus_addr), bb(bus_addr - 20'd1)}
                            : {bb(bus_addr + 20'd1), bb(bus_addr)};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) step();
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic eu_access(input logic we, input logic word, input logic [2:0] f,
                           input logic [15:0] seg, input logic [15:0] base,
                           input logic [15:0] idx, input logic [15:0] disp,
                           input logic [15:0] wd, output logic [15:0] rdata,
                           output logic [19:0] first_addr, output logic [1:0] first_be);
    logic [19:0] x;
    int          lat;
    wait_idle();
    x = phys(seg, base, idx, disp, f);
    push_bus(x, we, word, wd);
    push_ack(1'b0, !we, rd_exp(x, word));
    eu_we = we; eu_word = word; eu_factors = f; eu_segment = seg;
    eu_base = base; eu_index = idx; eu_disp = disp; eu_wdata = wd;
    eu_req = 1'b1;
    lat = 0;
    first_addr = '0;
    first_be   = '0;
    do begin
      step();
      lat++;
      if (lat == 1) begin
        first_addr = bus_addr;
        first_be   = bus_be;
      end
    end while (!eu_ack && lat < 50);
    if (!eu_ack) chk("eu_ack_timeout", 32'd1, 32'd0);
    chk("eu_latency", 32'(lat), (x[0] && word) ? 32'd3 : 32'd2);
    rdata  = eu_rdata;
    eu_req = 1'b0;
  endtask

  logic [15:0] rd;
  logic [19:0] fa;
  logic [1:0]  fb;
  int          n;

  initial begin
    reset_n = 1'b0;
    eu_req = 0; eu_we = 0; eu_word = 0; eu_factors = 0; eu_segment = 0;
    eu_base = 0; eu_index = 0; eu_disp = 0; eu_wdata = 0;
    pf_req = 0; pf_flush = 0; pf_segment = 0; pf_offset = 0;
    bus_ready = 1'b1;
    repeat (3) step();
    chk("rst_outputs", 32'(|{eu_ack, eu_rdata, pf_ack, pf_rdata, bus_req, bus_addr,
                             bus_we, bus_be, bus_wdata, busy}), 32'd0);
    reset_n = 1'b1;
    step();

    // Aligned word read.
    eu_access(1'b0, 1'b1, 3'b100, 16'h1000, 16'h0020, 16'h0, 16'h0, 16'h0, rd, fa, fb);
    chk("t1_addr", 32'(fa), 32'h10020);
    chk("t1_be", 32'(fb), 32'h3);

    // Odd word write split in two byte cycles.
    eu_access(1'b1, 1'b1, 3'b001, 16'h1000, 16'h0, 16'h0, 16'h0021, 16'hBEEF, rd, fa, fb);
    chk("t2_addr", 32'(fa), 32'h10021);
    chk("t2_be", 32'(fb), 32'h2);

    // Split word crossing the top of the address space.
    mem_ovr[20'hFFFFF] = 8'h34;
    mem_ovr[20'h00000] = 8'h12;
    eu_access(1'b0, 1'b1, 3'b001, 16'hFFFF, 16'h0, 16'h0, 16'h000F, 16'h0, rd, fa, fb);
    chk("t3_rdata", 32'(rd), 32'h1234);

    eu_access(1'b0, 1'b0, 3'b010, 16'h1234, 16'h0, 16'h0005, 16'h0, 16'h0, rd, fa, fb);
    eu_access(1'b1, 1'b0, 3'b111, 16'h0100, 16'h0010, 16'h0002, 16'h0004, 16'h55AA, rd, fa, fb);
    eu_access(1'b1, 1'b1, 3'b001, 16'h0800, 16'h0, 16'h0, 16'h0100, 16'hCAFE, rd, fa, fb);
    eu_access(1'b0, 1'b1, 3'b101, 16'h0500, 16'h0003, 16'h0, 16'h0010, 16'h0, rd, fa, fb);

    // Contention with STARVE_LIMIT=2: EU, EU, PF, EU, EU, PF.
    wait_idle();
    for (int k = 0; k < 6; k++) begin
      if (k == 2 || k == 5) begin
        push_bus(20'h20200, 1'b0, 1'b1, 16'h0);
        push_ack(1'b1, 1'b1, rd_exp(20'h20200, 1'b1));
      end else begin
        push_bus(20'h30010, 1'b0, 1'b1, 16'h0);
        push_ack(1'b0, 1'b1, rd_exp(20'h30010, 1'b1));
      end
    end
    eu_we = 0; eu_word = 1; eu_factors = 3'b001; eu_segment = 16'h3000; eu_disp = 16'h0010;
    pf_segment = 16'h2000; pf_offset = 16'h0200;
    eu_req = 1'b1;
    pf_req = 1'b1;
    n = 0;
    for (int c = 0; c < 100 && n < 6; c++) begin
      step();
      if (eu_ack || pf_ack) n++;
    end
    eu_req = 1'b0;
    pf_req = 1'b0;
    chk("cont_acks", 32'(n), 32'd6);

    // Flush during a stalled prefetch.
    wait_idle();
    bus_ready  = 1'b0;
    pf_segment = 16'h2000;
    pf_offset  = 16'h0104;
    push_bus(20'h20104, 1'b0, 1'b1, 16'h0);
    pf_req = 1'b1;
    step();
    chk("fl_breq1", 32'(bus_req), 32'd1);
    chk("fl_addr", 32'(bus_addr), 32'h20104);
    pf_flush = 1'b1;
    pf_req   = 1'b0;
    step();
    chk("fl_breq2", 32'(bus_req), 32'd1);
    pf_flush = 1'b0;
    step();
    chk("fl_breq3", 32'(bus_req), 32'd1);
    step();
    chk("fl_breq4", 32'(bus_req), 32'd1);
    bus_ready = 1'b1;
    step();
    chk("fl_no_ack", 32'(pf_ack), 32'd0);
    chk("fl_resp_busy", 32'(busy), 32'd1);
    step();
    chk("fl_idle", 32'(busy), 32'd0);
    eu_access(1'b0, 1'b1, 3'b001, 16'h0400, 16'h0, 16'h0, 16'h0040, 16'h0, rd, fa, fb);

    // Reset while in the second half of a split read.
    wait_idle();
    push_bus(20'h10031, 1'b0, 1'b0, 16'h0);
    eu_we = 0; eu_word = 1; eu_factors = 3'b001; eu_segment = 16'h1000; eu_disp = 16'h0031;
    eu_req = 1'b1;
    step();
    chk("rs_first", 32'(bus_addr), 32'h10031);
    step();
    chk("rs_second", 32'(bus_addr), 32'h10032);
    bus_ready = 1'b0;
    eu_req    = 1'b0;
    reset_n   = 1'b0;
    #1;
    chk("rs_outputs", 32'(|{eu_ack, eu_rdata, pf_ack, pf_rdata, bus_req, bus_addr,
                            bus_we, bus_be, bus_wdata, busy}), 32'd0);
    step();
    step();
    reset_n   = 1'b1;
    bus_ready = 1'b1;
    repeat (3) step();
    chk("rs_idle", 32'(busy), 32'd0);
    chk("rs_no_breq", 32'(bus_req), 32'd0);

    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
    chk("ack_q_empty", 32'(ack_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
